mul_seq_wb: RTL and testbench

Iterative 8x8 unsigned shift-add multiplier sitting directly downstream of the 8-entry register file's read ports and upstream of its write port. It captures the two operands read from the register file on `start`, computes the 16-bit product in 8 fixed cycles, then writes the high byte and the low byte back into the register file as two sequential single-cycle write strobes. Operands are latched at start, so the write-back cannot disturb an in-flight computation.

---
 rtl/mul_seq_wb_if.sv | 30 +++
 rtl/mul_seq_wb.sv | 128 ++++++++++++
 tb/tb_mul_seq_wb.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq_wb_if.sv
`timescale 1ns/1ps
// Bundle of the multiplier's request, register-file write-back and status
// signals. The multiplier takes the slave side; the surrounding logic (or a
// bench) takes the master side.
interface mul_seq_wb_if #(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = 3
);
   logic            start;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic [AW-1:0]   dst_hi;
   logic [AW-1:0]   dst_lo;
   logic            busy;
   logic            done;
   logic [2*W-1:0]  product;
   logic            rf_we;
   logic [AW-1:0]   rf_ptr;
   logic [W-1:0]    rf_di;

   modport master (
      output start, op_a, op_b, dst_hi, dst_lo,
      input  busy, done, product, rf_we, rf_ptr, rf_di
   );

   modport slave (
      input  start, op_a, op_b, dst_hi, dst_lo,
      output busy, done, product, rf_we, rf_ptr, rf_di
   );
endinterface

// File: rtl/mul_seq_wb.sv
`timescale 1ns/1ps
// Iterative WxW unsigned shift-add multiplier. Operands and destinations are
// captured on start, the product is built over W fixed cycles, then written
// back to the register file as high byte followed by low byte.
module mul_seq_wb #(
   parameter int unsigned W  = 8,
   parameter int unsigned AW = 3
) (
   input logic          clk,
   input logic          rst_n,
   mul_seq_wb_if.slave  bus
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      WBH  = 2'd2,
      WBL  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [W-1:0]      mcand_q, mcand_d;
   logic [W-1:0]      hi_q, hi_d;
   logic [W-1:0]      lo_q, lo_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     dhi_q, dhi_d;
   logic [AW-1:0]     dlo_q, dlo_d;
   logic [2*W-1:0]    product_q, product_d;
   logic              done_q, done_d;
   logic [W:0]        sum;
   logic              rf_we;
   logic [AW-1:0]     rf_ptr;
   logic [W-1:0]      rf_di;

   // State and datapath registers; synchronous active-low reset drops any
   // in-flight operation without issuing its write-back.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         dhi_q     <= '0;
         dlo_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         dhi_q     <= dhi_d;
         dlo_q     <= dlo_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   // Next-state, shift-add step and Moore write-back decode.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      dhi_d     = dhi_q;
      dlo_d     = dlo_q;
      product_d = product_q;
      done_d    = 1'b0;
      sum       = '0;
      rf_we     = 1'b0;
      rf_ptr    = '0;
      rf_di     = '0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d = bus.op_a;
               lo_d    = bus.op_b;
               hi_d    = '0;
               dhi_d   = bus.dst_hi;
               dlo_d   = bus.dst_lo;
               cnt_d   = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            // 9-bit sum keeps the carry so it shifts into hi's MSB.
            sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
            hi_d  = sum[W:1];
            lo_d  = {sum[0], lo_q[W-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d = WBH;
            end
         end
         WBH: begin
            rf_we   = 1'b1;
            rf_ptr  = dhi_q;
            rf_di   = hi_q;
            state_d = WBL;
         end
         WBL: begin
            rf_we     = 1'b1;
            rf_ptr    = dlo_q;
            rf_di     = lo_q;
            product_d = {hi_q, lo_q};
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.done    = done_q;
   assign bus.product = product_q;
   assign bus.rf_we   = rf_we;
   assign bus.rf_ptr  = rf_ptr;
   assign bus.rf_di   = rf_di;

endmodule

// File: tb/tb_mul_seq_wb.sv
`timescale 1ns/1ps
// Directed bench for mul_seq_wb: a small register-file model captures the
// write-back strobes, and each scenario checks cycle-exact behaviour.
module tb_mul_seq_wb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          errors = 0;

   logic [7:0]  a_drv = '0;
   logic [7:0]  b_drv = '0;
   logic        use_rf = 1'b0;
   logic [2:0]  ra = '0;
   logic [2:0]  rb = '0;
   logic        pre_we = 1'b0;
   logic [2:0]  pre_ptr = '0;
   logic [7:0]  pre_data = '0;

   logic [7:0]  rf [8];
   logic [10:0] wlog [64];
   int          wr_count = 0;

   mul_seq_wb_if #(.W(8), .AW(3)) bus ();

   mul_seq_wb #(.W(8), .AW(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   assign bus.op_a = use_rf ? rf[ra] : a_drv;
   assign bus.op_b = use_rf ? rf[rb] : b_drv;

   // Register-file model: preload port for the bench, otherwise the DUT writes.
   always @(posedge clk) begin
      if (pre_we) begin
         rf[pre_ptr] <= pre_data;
      end else if (bus.rf_we === 1'b1) begin
         rf[bus.rf_ptr]      <= bus.rf_di;
         wlog[wr_count % 64] <= {bus.rf_ptr, bus.rf_di};
         wr_count            <= wr_count + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at cycle 0 (idle); returns at cycle 1.
   task automatic issue(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] dh, input logic [2:0] dl);
      a_drv      = a;
      b_drv      = b;
      bus.dst_hi = dh;
      bus.dst_lo = dl;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.dst_hi = '0;
      bus.dst_lo = '0;
      tick();
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.rf_we); end
      checks++; if (bus.product !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", bus.product); end
      checks++; if ({bus.rf_ptr, bus.rf_di} !== 11'h000) begin errors++; $display("FAIL reset_ptr_di: got %h expected 000", {bus.rf_ptr, bus.rf_di}); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int base;
      base = wr_count;
      issue(8'd13, 8'd11, 3'd2, 3'd3);
      for (int c = 1; c <= 8; c++) begin
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy c%0d: got %b expected 1", c, bus.busy); end
         checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL basic_we_mul c%0d: got %b expected 0", c, bus.rf_we); end
         tick();
      end
      checks++; if ({bus.busy, bus.rf_we, bus.rf_ptr, bus.rf_di} !== {1'b1, 1'b1, 3'd2, 8'h00}) begin errors++; $display("FAIL basic_wbh: got busy/we/ptr/di %b/%b/%0d/%h expected 1/1/2/00", bus.busy, bus.rf_we, bus.rf_ptr, bus.rf_di); end
      tick();
      checks++; if ({bus.busy, bus.rf_we, bus.rf_ptr, bus.rf_di} !== {1'b1, 1'b1, 3'd3, 8'h8F}) begin errors++; $display("FAIL basic_wbl: got busy/we/ptr/di %b/%b/%0d/%h expected 1/1/3/8f", bus.busy, bus.rf_we, bus.rf_ptr, bus.rf_di); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b expected 0", bus.done); end
      tick();
      checks++; if ({bus.done, bus.busy, bus.rf_we} !== 3'b100) begin errors++; $display("FAIL basic_c11: got done/busy/we %b expected 100", {bus.done, bus.busy, bus.rf_we}); end
      checks++; if (bus.product !== 16'h008F) begin errors++; $display("FAIL basic_product: got %h expected 008f", bus.product); end
      checks++; if ({rf[2], rf[3]} !== 16'h008F) begin errors++; $display("FAIL basic_rf: got reg2/reg3 %h expected 008f", {rf[2], rf[3]}); end
      checks++; if (wr_count - base !== 2) begin errors++; $display("FAIL basic_nwrites: got %0d expected 2", wr_count - base); end
      tick();
      checks++; if ({bus.done, bus.product} !== {1'b0, 16'h008F}) begin errors++; $display("FAIL basic_hold: got done/product %b/%h expected 0/008f", bus.done, bus.product); end
   endtask

   task automatic test_max_zero();
      logic [7:0]  va [3];
      logic [7:0]  vb [3];
      logic [15:0] vp [3];
      va = '{8'hFF, 8'h00, 8'h37};
      vb = '{8'hFF, 8'h5A, 8'h00};
      vp = '{16'hFE01, 16'h0000, 16'h0000};
      for (int i = 0; i < 3; i++) begin
         issue(va[i], vb[i], 3'd0, 3'd7);
         repeat (9) tick();
         checks++; if ({bus.done, bus.busy} !== 2'b01) begin errors++; $display("FAIL maxzero_c10 v%0d: got done/busy %b expected 01", i, {bus.done, bus.busy}); end
         tick();
         checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL maxzero_done v%0d: got %b expected 1", i, bus.done); end
         checks++; if (bus.product !== vp[i]) begin errors++; $display("FAIL maxzero_product v%0d: got %h expected %h", i, bus.product, vp[i]); end
         checks++; if ({rf[0], rf[7]} !== vp[i]) begin errors++; $display("FAIL maxzero_rf v%0d: got %h expected %h", i, {rf[0], rf[7]}, vp[i]); end
         tick();
      end
   endtask

   task automatic test_same_dst();
      int base;
      base = wr_count;
      issue(8'h80, 8'h03, 3'd5, 3'd5);
      repeat (10) tick();
      checks++; if (bus.product !== 16'h0180) begin errors++; $display("FAIL samedst_product: got %h expected 0180", bus.product); end
      checks++; if (wr_count - base !== 2) begin errors++; $display("FAIL samedst_nwrites: got %0d expected 2", wr_count - base); end
      checks++; if (wlog[base % 64] !== {3'd5, 8'h01}) begin errors++; $display("FAIL samedst_w1: got %h expected %h", wlog[base % 64], {3'd5, 8'h01}); end
      checks++; if (wlog[(base + 1) % 64] !== {3'd5, 8'h80}) begin errors++; $display("FAIL samedst_w2: got %h expected %h", wlog[(base + 1) % 64], {3'd5, 8'h80}); end
      checks++; if (rf[5] !== 8'h80) begin errors++; $display("FAIL samedst_reg5: got %h expected 80", rf[5]); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic exp_done;
      logic exp_busy;
      a_drv      = 8'd7;
      b_drv      = 8'd9;
      bus.dst_hi = 3'd4;
      bus.dst_lo = 3'd6;
      bus.start  = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (c == 3)  a_drv = 8'hAA;
         if (c == 10) a_drv = 8'd7;
         if (c == 14) a_drv = 8'h55;
         if (c == 21) a_drv = 8'd7;
         exp_done = (c == 11) || (c == 22);
         exp_busy = !((c == 0) || (c == 11) || (c == 22));
         checks++; if (bus.done !== exp_done) begin errors++; $display("FAIL b2b_done c%0d: got %b expected %b", c, bus.done, exp_done); end
         checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL b2b_busy c%0d: got %b expected %b", c, bus.busy, exp_busy); end
         if (exp_done) begin
            checks++; if (bus.product !== 16'h003F) begin errors++; $display("FAIL b2b_product c%0d: got %h expected 003f", c, bus.product); end
         end
         tick();
      end
      bus.start = 1'b0;
      repeat (4) tick();
      checks++; if ({bus.busy, bus.product} !== {1'b0, 16'h003F}) begin errors++; $display("FAIL b2b_tail: got busy/product %b/%h expected 0/003f", bus.busy, bus.product); end
   endtask

   task automatic test_feedback();
      pre_we   = 1'b1;
      pre_ptr  = 3'd1;
      pre_data = 8'hC8;
      tick();
      pre_ptr  = 3'd4;
      pre_data = 8'h0B;
      tick();
      pre_we = 1'b0;
      use_rf = 1'b1;
      ra     = 3'd1;
      rb     = 3'd4;
      issue(8'h00, 8'h00, 3'd1, 3'd6);
      repeat (10) tick();
      checks++; if ({bus.done, bus.product} !== {1'b1, 16'h0898}) begin errors++; $display("FAIL feedback_product: got done/product %b/%h expected 1/0898", bus.done, bus.product); end
      checks++; if ({rf[1], rf[6]} !== 16'h0898) begin errors++; $display("FAIL feedback_rf: got reg1/reg6 %h expected 0898", {rf[1], rf[6]}); end
      use_rf = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      int base;
      issue(8'hFF, 8'hFF, 3'd2, 3'd3);
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if ({bus.busy, bus.done, bus.rf_we, bus.product} !== 19'h0) begin errors++; $display("FAIL rstmul_state: got busy/done/we/product %b/%b/%b/%h expected 0/0/0/0000", bus.busy, bus.done, bus.rf_we, bus.product); end
      base = wr_count;
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++; if ({bus.rf_we, bus.done, bus.busy} !== 3'b000) begin errors++; $display("FAIL rstmul_quiet c%0d: got we/done/busy %b expected 000", c, {bus.rf_we, bus.done, bus.busy}); end
      end
      checks++; if (wr_count - base !== 0) begin errors++; $display("FAIL rstmul_nwrites: got %0d expected 0", wr_count - base); end

      issue(8'hFF, 8'hFF, 3'd2, 3'd3);
      repeat (8) tick();
      checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL rstwbh_in_wbh: got %b expected 1", bus.rf_we); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if ({bus.busy, bus.done, bus.rf_we, bus.product} !== 19'h0) begin errors++; $display("FAIL rstwbh_state: got busy/done/we/product %b/%b/%b/%h expected 0/0/0/0000", bus.busy, bus.done, bus.rf_we, bus.product); end
      base = wr_count;
      for (int c = 0; c < 12; c++) begin
         tick();
         checks++; if ({bus.rf_we, bus.done, bus.busy} !== 3'b000) begin errors++; $display("FAIL rstwbh_quiet c%0d: got we/done/busy %b expected 000", c, {bus.rf_we, bus.done, bus.busy}); end
      end
      checks++; if (wr_count - base !== 0) begin errors++; $display("FAIL rstwbh_nwrites: got %0d expected 0", wr_count - base); end

      issue(8'h12, 8'h34, 3'd2, 3'd3);
      repeat (10) tick();
      checks++; if ({bus.done, bus.product} !== {1'b1, 16'h03A8}) begin errors++; $display("FAIL rst_recover: got done/product %b/%h expected 1/03a8", bus.done, bus.product); end
      checks++; if ({rf[2], rf[3]} !== 16'h03A8) begin errors++; $display("FAIL rst_recover_rf: got %h expected 03a8", {rf[2], rf[3]}); end
      tick();
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.dst_hi = '0;
      bus.dst_lo = '0;
      test_reset();
      test_basic();
      test_max_zero();
      test_same_dst();
      test_back_to_back();
      test_feedback();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
